// File: rtl/gl_imem_arbiter.sv
// Instruction BRAM arbiter: single-word fetch reads vs. multi-word operand bursts,
// with issue tagging of returning data. Define GL_IMEM_STARVE_GUARD_EN for the fetch starvation guard.
module gl_imem_arbiter #(
    parameter int width        = 32,
    parameter int starve_limit = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_req,
    input  logic [width-1:0] f_addr,
    output logic             f_gnt,
    output logic             fetch_stall,
    output logic             f_valid,
    output logic [width-1:0] f_data,
    input  logic             o_req,
    input  logic [width-1:0] o_addr,
    input  logic [3:0]       o_len,
    output logic             o_gnt,
    output logic             o_busy,
    output logic             o_valid,
    output logic [width-1:0] o_data,
    output logic             o_last,
    output logic             mem_en,
    output logic [width-1:0] mem_addr,
    input  logic [width-1:0] mem_rdata
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [1:0] TAG_NONE    = 2'd0;
    localparam logic [1:0] TAG_FETCH   = 2'd1;
    localparam logic [1:0] TAG_OP      = 2'd2;
    localparam logic [1:0] TAG_OP_LAST = 2'd3;

    state_t           state_q, state_n;
    logic [width-1:0] addr_q, addr_n;
    logic [3:0]       cnt_q, cnt_n;
    logic [1:0]       tag_q, tag_n;
    logic [width-1:0] f_hold_q, o_hold_q;
    logic             force_fetch;

`ifdef GL_IMEM_STARVE_GUARD_EN
    localparam int SW = $clog2(starve_limit + 1);
    logic [SW-1:0] starve_q;

    always_ff @(posedge clk) begin
        if (!reset || f_gnt)
            starve_q <= '0;
        else if (fetch_stall && starve_q != SW'(starve_limit))
            starve_q <= starve_q + SW'(1);
    end

    assign force_fetch = f_req && (starve_q == SW'(starve_limit));
`else
    assign force_fetch = 1'b0;
`endif

    // cnt_q holds words still to issue after the current one, so the last issue sees 0
    always_comb begin
        state_n  = state_q;
        addr_n   = addr_q;
        cnt_n    = cnt_q;
        tag_n    = TAG_NONE;
        f_gnt    = 1'b0;
        o_gnt    = 1'b0;
        o_busy   = 1'b0;
        mem_en   = 1'b0;
        mem_addr = '0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (o_req && !force_fetch) begin
                        o_gnt    = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = o_addr;
                        addr_n   = o_addr + width'(1);
                        if (o_len != 4'd0) begin
                            cnt_n   = o_len - 4'd1;
                            tag_n   = TAG_OP;
                            state_n = BURST;
                        end else begin
                            tag_n   = TAG_OP_LAST;
                        end
                    end else if (f_req) begin
                        f_gnt    = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = f_addr;
                        tag_n    = TAG_FETCH;
                    end
                end
                BURST: begin
                    o_busy   = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = addr_q;
                    addr_n   = addr_q + width'(1);
                    if (cnt_q == 4'd0) begin
                        tag_n   = TAG_OP_LAST;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = cnt_q - 4'd1;
                        tag_n   = TAG_OP;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign fetch_stall = reset && f_req && !f_gnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            tag_q    <= TAG_NONE;
            f_hold_q <= '0;
            o_hold_q <= '0;
        end else begin
            state_q  <= state_n;
            addr_q   <= addr_n;
            cnt_q    <= cnt_n;
            tag_q    <= tag_n;
            if (f_valid) f_hold_q <= mem_rdata;
            if (o_valid) o_hold_q <= mem_rdata;
        end
    end

    // Returning data is steered by the tag of the previous cycle's issue
    assign f_valid = reset && (tag_q == TAG_FETCH);
    assign o_valid = reset && tag_q[1];
    assign o_last  = reset && (tag_q == TAG_OP_LAST);
    assign f_data  = !reset ? '0 : (f_valid ? mem_rdata : f_hold_q);
    assign o_data  = !reset ? '0 : (o_valid ? mem_rdata : o_hold_q);

endmodule

// File: tb/tb_gl_imem_arbiter.sv
// Directed bench for gl_imem_arbiter: vector table for single-cycle arbitration,
// hand sequences for bursts, address wrap, mid-burst reset and the starvation guard.
module tb_gl_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, o_req;
    logic [31:0] f_addr, o_addr;
    logic [3:0]  o_len;
    logic        f_gnt, fetch_stall, f_valid, o_gnt, o_busy, o_valid, o_last, mem_en;
    logic [31:0] f_data, o_data, mem_addr, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gl_imem_arbiter #(.width(32), .starve_limit(4)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .fetch_stall(fetch_stall),
        .f_valid(f_valid), .f_data(f_data),
        .o_req(o_req), .o_addr(o_addr), .o_len(o_len), .o_gnt(o_gnt), .o_busy(o_busy),
        .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] md(input logic [31:0] a);
        return (a == 32'h10) ? 32'hA5 : {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) mem_rdata <= mem_en ? md(mem_addr) : 32'h0BAD0BAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        o_req;
        logic [31:0] o_addr;
        logic        e_f_gnt, e_o_gnt, e_mem_en;
        logic [31:0] e_mem_addr;
        logic        e_stall, e_f_valid;
        logic [31:0] e_f_data;
        logic        e_o_valid;
        logic [31:0] e_o_data;
        logic        e_o_last;
    } vec_t;

    vec_t vt[8];

    initial begin
        // f_req f_addr o_req o_addr | f_gnt o_gnt mem_en mem_addr stall f_valid f_data o_valid o_data o_last
        vt[0] = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0};
        vt[1] = '{1'b1, 32'h10,       1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h10,       1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0};
        vt[2] = '{1'b0, 32'h0,        1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h20,       1'b0, 1'b1, 32'hA5,    1'b0, 32'h0,     1'b0};
        vt[3] = '{1'b0, 32'h0,        1'b1, 32'h21, 1'b0, 1'b1, 1'b1, 32'h21,       1'b0, 1'b0, 32'hA5,    1'b1, md(32'h20), 1'b1};
        vt[4] = '{1'b1, 32'h40,       1'b1, 32'h30, 1'b0, 1'b1, 1'b1, 32'h30,       1'b1, 1'b0, 32'hA5,    1'b1, md(32'h21), 1'b1};
        vt[5] = '{1'b1, 32'h40,       1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h40,       1'b0, 1'b0, 32'hA5,    1'b1, md(32'h30), 1'b1};
        vt[6] = '{1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, md(32'h40), 1'b0, md(32'h30), 1'b0};
        vt[7] = '{1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, md(32'hFFFFFFFF), 1'b0, md(32'h30), 1'b0};

        // Reset with both requests asserted: every output must still be 0
        reset = 1'b0; f_req = 1'b1; f_addr = 32'h10; o_req = 1'b1; o_addr = 32'h20; o_len = 4'd3;
        @(negedge clk);
        chk("rst_f_gnt", f_gnt, 0);  chk("rst_o_gnt", o_gnt, 0);
        chk("rst_mem_en", mem_en, 0); chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stall", fetch_stall, 0); chk("rst_o_busy", o_busy, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_f_valid", f_valid, 0); chk("rst_f_data", f_data, 0);
        chk("rst_o_valid", o_valid, 0); chk("rst_o_data", o_data, 0); chk("rst_o_last", o_last, 0);
        reset = 1'b1; f_req = 1'b0; o_req = 1'b0; o_len = 4'd0;

        for (int i = 0; i < 8; i++) begin
            f_req = vt[i].f_req; f_addr = vt[i].f_addr; o_req = vt[i].o_req; o_addr = vt[i].o_addr;
            @(negedge clk);
            chk($sformatf("v%0d_f_gnt", i), f_gnt, vt[i].e_f_gnt);
            chk($sformatf("v%0d_o_gnt", i), o_gnt, vt[i].e_o_gnt);
            chk($sformatf("v%0d_mem_en", i), mem_en, vt[i].e_mem_en);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_mem_addr);
            chk($sformatf("v%0d_stall", i), fetch_stall, vt[i].e_stall);
            chk($sformatf("v%0d_o_busy", i), o_busy, 0);
            chk($sformatf("v%0d_f_valid", i), f_valid, vt[i].e_f_valid);
            chk($sformatf("v%0d_f_data", i), f_data, vt[i].e_f_data);
            chk($sformatf("v%0d_o_valid", i), o_valid, vt[i].e_o_valid);
            chk($sformatf("v%0d_o_data", i), o_data, vt[i].e_o_data);
            chk($sformatf("v%0d_o_last", i), o_last, vt[i].e_o_last);
            @(posedge clk);
            #1;
        end

        // 16-word burst with fetch waiting behind it
        o_req = 1'b1; o_addr = 32'h20; o_len = 4'd15; f_req = 1'b1; f_addr = 32'h50;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk($sformatf("b16_o_gnt_%0d", k), o_gnt, k == 0);
            chk($sformatf("b16_f_gnt_%0d", k), f_gnt, k == 16);
            chk($sformatf("b16_stall_%0d", k), fetch_stall, k <= 15);
            chk($sformatf("b16_o_busy_%0d", k), o_busy, k >= 1 && k <= 15);
            chk($sformatf("b16_mem_en_%0d", k), mem_en, k <= 16);
            if (k <= 15) chk($sformatf("b16_mem_addr_%0d", k), mem_addr, 32'h20 + 32'(k));
            if (k == 16) chk("b16_mem_addr_fetch", mem_addr, 32'h50);
            chk($sformatf("b16_o_valid_%0d", k), o_valid, k >= 1 && k <= 16);
            chk($sformatf("b16_o_last_%0d", k), o_last, k == 16);
            if (k >= 1 && k <= 16) chk($sformatf("b16_o_data_%0d", k), o_data, md(32'h1F + 32'(k)));
            chk($sformatf("b16_f_valid_%0d", k), f_valid, k == 17);
            if (k == 17) chk("b16_f_data", f_data, md(32'h50));
            @(posedge clk);
            #1;
            if (k == 0) o_req = 1'b0;
            if (k == 16) f_req = 1'b0;
        end

        // Address wrap across 0xFFFFFFFF
        o_req = 1'b1; o_addr = 32'hFFFFFFFE; o_len = 4'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("wrap_mem_en_%0d", k), mem_en, k <= 3);
            if (k <= 3) chk($sformatf("wrap_mem_addr_%0d", k), mem_addr, 32'hFFFFFFFE + 32'(k));
            chk($sformatf("wrap_o_valid_%0d", k), o_valid, k >= 1);
            chk($sformatf("wrap_o_last_%0d", k), o_last, k == 4);
            if (k >= 1) chk($sformatf("wrap_o_data_%0d", k), o_data, md(32'hFFFFFFFD + 32'(k)));
            @(posedge clk);
            #1;
            if (k == 0) o_req = 1'b0;
        end

        // Reset during the issue of word 5 of a 16-word burst
        o_req = 1'b1; o_addr = 32'h100; o_len = 4'd15;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mr_mem_addr_%0d", k), mem_addr, 32'h100 + 32'(k));
            chk($sformatf("mr_o_busy_%0d", k), o_busy, k >= 1);
            @(posedge clk);
            #1;
            o_req = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        chk("mr_rst_mem_en", mem_en, 0); chk("mr_rst_o_busy", o_busy, 0); chk("mr_rst_o_valid", o_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mr_post_mem_en", mem_en, 0); chk("mr_post_o_busy", o_busy, 0);
        chk("mr_post_o_valid", o_valid, 0); chk("mr_post_o_data", o_data, 0); chk("mr_post_f_valid", f_valid, 0);
        @(posedge clk);
        #1;
        f_req = 1'b1; f_addr = 32'h10;
        @(negedge clk);
        chk("mr_fetch_gnt", f_gnt, 1); chk("mr_fetch_addr", mem_addr, 32'h10); chk("mr_fetch_stall", fetch_stall, 0);
        @(posedge clk);
        #1;
        f_req = 1'b0;
        @(negedge clk);
        chk("mr_fetch_valid", f_valid, 1); chk("mr_fetch_data", f_data, 32'hA5);
        @(posedge clk);
        #1;

`ifdef GL_IMEM_STARVE_GUARD_EN
        // starve_limit=4: four operand grants, then fetch, then the count restarts
        o_req = 1'b1; o_addr = 32'h200; o_len = 4'd0; f_req = 1'b1; f_addr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("sg_f_gnt_%0d", k), f_gnt, k == 4 || k == 9);
            chk($sformatf("sg_o_gnt_%0d", k), o_gnt, !(k == 4 || k == 9));
            chk($sformatf("sg_mem_addr_%0d", k), mem_addr, (k == 4 || k == 9) ? 32'h300 : 32'h200);
            @(posedge clk);
            #1;
        end
        o_req = 1'b0; f_req = 1'b0;
        @(posedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
